// File: rtl/permutation_iter.sv
// Iterative ASCON permutation: one round (pC -> pS -> pL) per clock on a 320-bit state register.
// Words are packed x0 in [319:256] down to x4 in [63:0]; p12 starts at round 0, p6 at round 6.

module substitution_layer (
  input  logic [319:0] state_i,
  output logic [319:0] state_o
);
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;

  // Bitsliced 5-bit S-box, one column per bit position, x0 is the column MSB
  always_comb begin
    x0 = state_i[319:256] ^ state_i[63:0];
    x1 = state_i[255:192];
    x2 = state_i[191:128] ^ state_i[255:192];
    x3 = state_i[127:64];
    x4 = state_i[63:0] ^ state_i[127:64];

    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;

    a0 = x0 ^ t1;
    a1 = x1 ^ t2;
    a2 = x2 ^ t3;
    a3 = x3 ^ t4;
    a4 = x4 ^ t0;

    b1 = a1 ^ a0;
    b0 = a0 ^ a4;
    b3 = a3 ^ a2;
    b2 = ~a2;
    b4 = a4;

    state_o = {b0, b1, b2, b3, b4};
  end
endmodule

// state | meaning
// IDLE  | waiting for an accepted start; state register holds the last result
// RUN   | one round per cycle, cnt is the round index being applied
// DONE  | result valid, done_o pulses for this single cycle
module permutation_iter #(
  parameter int NB_ROUNDS = 12
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [3:0]   round_start_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [319:0] state_q, state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [319:0] pc_out;
  logic [319:0] ps_out;
  logic [319:0] pl_out;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  always_comb begin
    pc_out = state_q;
    pc_out[135:128] = state_q[135:128] ^ {4'hF - cnt_q, cnt_q};
  end

  substitution_layer u_sbox (
    .state_i (pc_out),
    .state_o (ps_out)
  );

  always_comb begin
    logic [63:0] w0, w1, w2, w3, w4;
    w0 = ps_out[319:256];
    w1 = ps_out[255:192];
    w2 = ps_out[191:128];
    w3 = ps_out[127:64];
    w4 = ps_out[63:0];
    pl_out = {w0 ^ ror64(w0, 19) ^ ror64(w0, 28),
              w1 ^ ror64(w1, 61) ^ ror64(w1, 39),
              w2 ^ ror64(w2, 1)  ^ ror64(w2, 6),
              w3 ^ ror64(w3, 10) ^ ror64(w3, 17),
              w4 ^ ror64(w4, 7)  ^ ror64(w4, 41)};
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i && (round_start_i <= LAST_ROUND)) begin
          state_d = state_i;
          cnt_d   = round_start_i;
          fsm_d   = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        state_d = pl_out;
        // counter holds at the last round index instead of wrapping
        if (cnt_q == LAST_ROUND) begin
          fsm_d  = DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= 4'd0;
      state_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign state_o = state_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
endmodule
